// File: rtl/iob_bus_merge2_pkg.sv
// Shared constants and the read/write classification rule for the two-to-one IOb bus merge.
package iob_bus_merge2_pkg;

  localparam logic M0_ID      = 1'b0;
  localparam logic M1_ID      = 1'b1;
  localparam int   RD_AW_DEF  = 2;
  localparam int   MAX_STRB_W = 128;

  // A request with no byte strobes set is a read; callers zero-extend their strobes.
  function automatic logic is_read_f(input logic [MAX_STRB_W-1:0] wstrb);
    return (wstrb == '0);
  endfunction

endpackage

// File: rtl/iob_bus_merge2_fifo.sv
// Register FIFO of 1-bit requester IDs; wrap-bit pointers give full/empty without a counter.
module iob_bus_merge2_fifo
  import iob_bus_merge2_pkg::*;
#(
  parameter int AW = RD_AW_DEF
) (
  input  logic clk_i,
  input  logic cke_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int DEPTH = 2 ** AW;

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [DEPTH-1:0] mem_q, mem_d;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (push_i && !full_o) begin
      mem_d[wptr_q[AW-1:0]] = data_i;
      wptr_d                = wptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop_i && !empty_o) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '0;
    end else if (cke_i) begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/iob_bus_merge2.sv
// Two-to-one IOb bus arbiter with in-order read response routing.
// Define IOB_BUS_MERGE2_RR_EN for round-robin ties; otherwise requester 1 always wins ties.
module iob_bus_merge2
  import iob_bus_merge2_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_AW  = RD_AW_DEF
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                m0_valid_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_ready_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_valid_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_ready_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_valid_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic                s_ready_i,
  input  logic                s_rvalid_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                err_o
);

  // Handshake: a beat transfers on a port in any cycle where its valid and ready are both high.

  logic                gnt;
  logic                g_valid;
  logic [DATA_W/8-1:0] g_wstrb;
  logic [MAX_STRB_W-1:0] g_wstrb_ext;
  logic                g_read;
  logic                blocked;
  logic                accept;
  logic                fifo_full, fifo_empty, fifo_head;
  logic                err_q, err_d;
  logic                tie_winner;

`ifdef IOB_BUS_MERGE2_RR_EN
  logic lg_q, lg_d;

  assign tie_winner = ~lg_q;
  assign lg_d       = accept ? gnt : lg_q;

  // lg resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk_i) begin
    if (arst_i)     lg_q <= M1_ID;
    else if (cke_i) lg_q <= lg_d;
  end
`else
  assign tie_winner = M1_ID;
`endif

  always_comb begin
    gnt = m1_valid_i ? M1_ID : M0_ID;
    if (m0_valid_i && m1_valid_i) gnt = tie_winner;
  end

  assign g_valid     = (gnt == M1_ID) ? m1_valid_i : m0_valid_i;
  assign g_wstrb     = (gnt == M1_ID) ? m1_wstrb_i : m0_wstrb_i;
  assign g_wstrb_ext = MAX_STRB_W'(g_wstrb);
  assign g_read      = is_read_f(g_wstrb_ext);

  // Full only blocks reads; it never looks at s_rvalid_i so the request side stays free of it.
  assign blocked = g_read & fifo_full;
  assign accept  = s_valid_o & s_ready_i;

  assign s_valid_o  = g_valid & ~blocked;
  assign s_addr_o   = (gnt == M1_ID) ? m1_addr_i : m0_addr_i;
  assign s_wdata_o  = (gnt == M1_ID) ? m1_wdata_i : m0_wdata_i;
  assign s_wstrb_o  = g_wstrb;

  assign m0_ready_o = m0_valid_i & (gnt == M0_ID) & s_ready_i & ~blocked;
  assign m1_ready_o = m1_valid_i & (gnt == M1_ID) & s_ready_i & ~blocked;

  iob_bus_merge2_fifo #(.AW(RD_AW)) u_order_fifo (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .rst_i   (arst_i),
    .push_i  (accept & g_read),
    .data_i  (gnt),
    .pop_i   (s_rvalid_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign m0_rvalid_o = s_rvalid_i & ~fifo_empty & (fifo_head == M0_ID);
  assign m1_rvalid_o = s_rvalid_i & ~fifo_empty & (fifo_head == M1_ID);

  assign err_d = err_q | (s_rvalid_i & fifo_empty);
  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (arst_i)     err_q <= 1'b0;
    else if (cke_i) err_q <= err_d;
  end

endmodule

// File: tb/tb_iob_bus_merge2.sv
// Directed bench for iob_bus_merge2; expectations follow IOB_BUS_MERGE2_RR_EN if defined.
module tb_iob_bus_merge2;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          cke, arst;
  logic          m0_valid, m1_valid, m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [3:0]    m0_wstrb, m1_wstrb, s_wstrb;
  logic          s_valid, s_ready, s_rvalid, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iob_bus_merge2 #(.ADDR_W(AW), .DATA_W(DW), .RD_AW(2)) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .m0_valid_i(m0_valid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
    .m0_ready_o(m0_ready), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_valid_i(m1_valid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
    .m1_ready_o(m1_ready), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ready_i(s_ready), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .err_o(err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;
  endtask

  task automatic m0_rd(input logic [AW-1:0] a);
    m0_valid = 1'b1; m0_addr = a; m0_wstrb = 4'h0;
  endtask

  task automatic m1_rd(input logic [AW-1:0] a);
    m1_valid = 1'b1; m1_addr = a; m1_wstrb = 4'h0;
  endtask

  task automatic rsp(input logic [DW-1:0] d);
    s_rvalid = 1'b1; s_rdata = d;
  endtask

  logic [3:0] exp_g;
  logic [DW-1:0] drain_d [4];
  logic          drain_id [4];

  initial begin
    cke = 1'b1;
    arst = 1'b0;
    idle();
    do_reset();

    // Reset state with the shared port not ready.
    s_ready = 1'b0; s_rdata = 32'h0000_1234;
    look();
    check("rst_s_valid", s_valid, 0);
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_err", err, 0);
    check("rst_rdata_bcast", m0_rdata, 32'h0000_1234);
    tick();

    // Clock enable low: a stray response must not set err.
    idle(); cke = 1'b0; s_rvalid = 1'b1;
    tick();
    s_rvalid = 1'b0; cke = 1'b1;
    look();
    check("cke_hold_err", err, 0);
    tick();

    // m0 single read, latency 1.
    m0_rd(32'h100);
    look();
    check("rd_s_valid", s_valid, 1);
    check("rd_s_addr", s_addr, 32'h100);
    check("rd_m0_ready", m0_ready, 1);
    check("rd_m1_ready", m1_ready, 0);
    tick();
    idle(); rsp(32'hDEAD_BEEF);
    look();
    check("rd_m0_rvalid", m0_rvalid, 1);
    check("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("rd_m1_rvalid", m1_rvalid, 0);
    tick();
    idle();

    // Both requesters writing for four accepted cycles after reset.
    do_reset();
`ifdef IOB_BUS_MERGE2_RR_EN
    exp_g = 4'b1010;
`else
    exp_g = 4'b1111;
`endif
    m0_valid = 1'b1; m0_addr = 32'hA0; m0_wstrb = 4'hF; m0_wdata = 32'h1;
    m1_valid = 1'b1; m1_addr = 32'hB0; m1_wstrb = 4'hF; m1_wdata = 32'h2;
    for (int k = 0; k < 4; k++) begin
      look();
      check($sformatf("arb%0d_s_addr", k), s_addr, exp_g[k] ? 32'hB0 : 32'hA0);
      check($sformatf("arb%0d_m0_ready", k), m0_ready, !exp_g[k]);
      check($sformatf("arb%0d_m1_ready", k), m1_ready, exp_g[k]);
      tick();
    end
    idle();

    // Interleaved reads m0, m1, m0 with latency 3.
    m0_rd(32'h0); tick(); idle();
    m1_rd(32'h4); tick(); idle();
    m0_rd(32'h8); tick(); idle();
    rsp(32'h11); look();
    check("il0_m0_rvalid", m0_rvalid, 1);
    check("il0_m1_rvalid", m1_rvalid, 0);
    check("il0_rdata", m0_rdata, 32'h11);
    tick();
    rsp(32'h22); look();
    check("il1_m0_rvalid", m0_rvalid, 0);
    check("il1_m1_rvalid", m1_rvalid, 1);
    check("il1_rdata", m1_rdata, 32'h22);
    tick();
    rsp(32'h33); look();
    check("il2_m0_rvalid", m0_rvalid, 1);
    check("il2_m1_rvalid", m1_rvalid, 0);
    tick();
    idle();

    // Fill the order FIFO with four m0 reads; the fifth is blocked.
    for (int k = 0; k < 4; k++) begin
      m0_rd(32'h200 + 32'(k * 4));
      look();
      check($sformatf("fill%0d_m0_ready", k), m0_ready, 1);
      tick();
    end
    m0_rd(32'h210);
    look();
    check("full_s_valid", s_valid, 0);
    check("full_m0_ready", m0_ready, 0);
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      m1_valid = 1'b1; m1_addr = 32'h300 + 32'(k * 4); m1_wstrb = 4'h3; m1_wdata = 32'(k);
      look();
      check($sformatf("wburst%0d_m1_ready", k), m1_ready, 1);
      check($sformatf("wburst%0d_s_wstrb", k), s_wstrb, 4'h3);
      tick();
    end
    idle();

    // Pop to count 3, then pop and push together.
    rsp(32'h44); look();
    check("pop_m0_rvalid", m0_rvalid, 1);
    tick();
    idle(); rsp(32'h55); m1_rd(32'h400);
    look();
    check("pp_m0_rvalid", m0_rvalid, 1);
    check("pp_m1_ready", m1_ready, 1);
    tick();
    idle(); m0_rd(32'h404);
    look();
    check("pp_cnt3_m0_ready", m0_ready, 1);
    tick();
    idle(); m0_rd(32'h408);
    look();
    check("pp_cnt4_s_valid", s_valid, 0);
    tick();
    idle();
    drain_id[0] = 1'b0; drain_id[1] = 1'b0; drain_id[2] = 1'b1; drain_id[3] = 1'b0;
    drain_d[0] = 32'hC0; drain_d[1] = 32'hC1; drain_d[2] = 32'hC2; drain_d[3] = 32'hC3;
    for (int k = 0; k < 4; k++) begin
      rsp(drain_d[k]);
      look();
      check($sformatf("drain%0d_m0_rvalid", k), m0_rvalid, !drain_id[k]);
      check($sformatf("drain%0d_m1_rvalid", k), m1_rvalid, drain_id[k]);
      tick();
    end
    idle();
    look();
    check("pre_err", err, 0);

    // Response with nothing outstanding.
    rsp(32'h66);
    look();
    check("orphan_m0_rvalid", m0_rvalid, 0);
    check("orphan_m1_rvalid", m1_rvalid, 0);
    tick();
    idle();
    look();
    check("orphan_err", err, 1);
    tick(); tick();
    look();
    check("orphan_err_sticky", err, 1);

    // Reset with a read in flight; its late response is stale.
    do_reset();
    look();
    check("rst2_err", err, 0);
    m1_rd(32'h500);
    tick();
    idle();
    do_reset();
    rsp(32'h77);
    look();
    check("stale_m1_rvalid", m1_rvalid, 0);
    tick();
    idle();
    look();
    check("stale_err", err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
